uart_rx: RTL
============

# uart_rx

16x-oversampling UART receiver. It deserialises 8N1-style frames from the asynchronous `rx` line into parallel bytes, advancing only on single-cycle `s_tick` enables from the baud-rate tick timer (16 ticks per bit period). It is the receive-side peer of the UART transmitter and pushes each completed byte to the downstream RX FIFO or consumer via a one-cycle `rx_done_tick` strobe.

## Interface
- `DBIT`, default 8: data bits per frame. Legal range 5–9.
- `SB_TICK`, default 16: stop-bit length in `s_tick`s. 16, 24 or 32 give 1, 1.5 or 2 stop bits. Minimum 16.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial line, asynchronous to `clk`; idles high.
- `s_tick`  in  1  oversample enable, one `clk` wide, 16 per bit period.
- `rx_dout`  out  DBIT  last received data word; LSB is the first bit received.
- `rx_done_tick`  out  1  one-cycle strobe: `rx_dout` and `framing_err` have just updated.
- `framing_err`  out  1  the stop bit of the last frame was sampled low.

## Operation
- **Input synchronizer.** `rx` passes through two flops before any use; the result is `rx_s`. Both flops reset to 1.
- **Counters.**
  - Tick counter `s` is 5 bits and counts `s_tick`s within a bit.
  - Bit counter `n` is `$clog2(DBIT)` bits.
  - Shift register `b` is `DBIT` bits.
  - Counters change only in the cycles noted below; with no `s_tick`, all state holds.
- **State machine: IDLE, START, DATA, STOP.** Reset state is IDLE.
- **IDLE.** When `rx_s`==0, go to START with `s`=0. This check is made on every `clk`, not gated by `s_tick`.
- **START.** On `s_tick`:
  - If `s`==7 (mid start bit): if `rx_s`==0, go to DATA with `s`=0 and `n`=0. Otherwise the start was false: go to IDLE with no strobe.
  - Otherwise `s`++.
- **DATA.** On `s_tick`:
  - If `s`==15: `s`=0, `b`={`rx_s`, `b[DBIT-1:1]`}. If `n`==DBIT-1, go to STOP. Otherwise `n`++.
  - Otherwise `s`++.
- **STOP.** On `s_tick`:
  - At `s`==15, capture the stop-bit sample (mid stop bit).
  - At `s`==SB_TICK-1, go to IDLE and, on the same edge:
    - `rx_dout` ⇐ `b`;
    - `framing_err` ⇐ ~stop sample;
    - `rx_done_tick` ⇐ 1.
  - Otherwise `s`++.
  - With `SB_TICK`=16 both events fall on the same tick.
- **Output registers.** `rx_dout` and `framing_err` are registered. They change only at a done event and otherwise hold, so mid-frame shifting is never visible on `rx_dout`.
- **Framing error.** A frame with a low stop bit still delivers its data with `framing_err`=1. If `rx` stays low (break), IDLE re-enters START on the next cycle. Each frame period then delivers 0x00 with `framing_err`=1.
- **Reset.** Reset mid-frame abandons the frame:
  - state = IDLE; `s`, `n`, `b` = 0;
  - `rx_dout` = 0, `framing_err` = 0, `rx_done_tick` = 0;
  - synchronizer flops = 1.
- **Simultaneous `reset` and `s_tick`.** Reset wins.

## Timing
- Reset values: `rx_dout`=0, `rx_done_tick`=0, `framing_err`=0.
- Start detection: a falling edge on `rx` reaches `rx_s` 2 `clk` later, and IDLE→START happens on the following edge.
- Sample points (counting `s_tick`s after START entry):
  - start-bit check on the 8th;
  - data bit k on the 8+16(k+1)th;
  - stop sample at 8+16(DBIT+1).
- `rx_done_tick` is high for exactly one `clk`. It rises on the edge that consumes `s_tick` number 8+16·DBIT+SB_TICK after START entry; for defaults, the 152nd.
- Back-to-back frames: the next start bit can be detected in the cycle after the return to IDLE. No idle gap is required beyond the stop period.
- Throughput: one frame per (1+DBIT)·16+SB_TICK ticks. `s_tick` spacing of ≥1 `clk` is supported, including `s_tick` held continuously high.

## Test plan
- **Reset.** Assert `reset` 3 cycles with `rx`=1 → `rx_dout`=0x00, `rx_done_tick`=0, `framing_err`=0; no strobe for 1000 cycles of idle line.
- **Single frame.** `s_tick` every 4 `clk`; send 0x55 with a valid stop bit → exactly one `rx_done_tick` pulse, `rx_dout`=0x55, `framing_err`=0. `rx_dout` unchanged during the frame.
- **Glitch rejection.** Drive `rx` low for 4 ticks then high → no strobe and FSM back in IDLE. A following frame 0xA3 → `rx_dout`=0xA3.
- **Framing error.** Send 0x0F with the stop bit driven low → one strobe, `rx_dout`=0x0F, `framing_err`=1. A following good frame 0x81 → `framing_err`=0.
- **Back-to-back frames.** Send 0x00 then 0xFF with zero idle gap → two strobes exactly 160 ticks apart, with data 0x00 then 0xFF.
- **Reset mid-frame.** Pulse `reset` for one `clk` after 3 data bits of 0xC3 → all outputs 0, no strobe. The next full frame 0x3C → `rx_dout`=0x3C, `framing_err`=0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (clk, reset, rx, s_tick -> rx_dout, rx_done_tick, framing_err)
module uart_rx #(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            framing_err
);
  localparam int NW = $clog2(DBIT);
  localparam logic [NW-1:0] NL = NW'(DBIT - 1);
  localparam logic [4:0] SL = 5'(SB_TICK - 1);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] state;
  logic [4:0] s;
  logic [NW-1:0] n;
  logic [DBIT-1:0] b;
  logic sync1, rx_s, stop_q, stop_smp;
  assign stop_smp = (s == 5'd15) ? rx_s : stop_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s <= '0;
      n <= '0;
      b <= '0;
      sync1 <= 1'b1;
      rx_s <= 1'b1;
      stop_q <= 1'b0;
      rx_dout <= '0;
      framing_err <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      sync1 <= rx;
      rx_s <= sync1;
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          s <= '0;
        end
        START: if (s_tick) begin
          if (s == 5'd7) begin
            state <= rx_s ? IDLE : DATA;
            s <= '0;
            n <= '0;
          end else s <= s + 5'd1;
        end
        DATA: if (s_tick) begin
          if (s == 5'd15) begin
            s <= '0;
            b <= {rx_s, b[DBIT-1:1]};
            if (n == NL) state <= STOP;
            else n <= n + NW'(1);
          end else s <= s + 5'd1;
        end
        STOP: if (s_tick) begin
          if (s == 5'd15) stop_q <= rx_s;
          if (s == SL) begin
            state <= IDLE;
            rx_dout <= b;
            framing_err <= ~stop_smp;
            rx_done_tick <= 1'b1;
          end else s <= s + 5'd1;
        end
      endcase
    end
  end
endmodule
